// File: rtl/music_seq_pkg.sv
// music_seq_pkg: shared FSM state type and widths for the music sequencer
package music_seq_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, WAIT, ADV} music_seq_state_t;
    localparam int DUR_W     = 8;
    localparam int NOTE_REST = 0;
endpackage

// File: rtl/music_seq_table.sv
// music_seq_table: song table, NUM_ENTRIES x (note, duration) register file
//   i_clk, i_rst        : clock, asynchronous active-high clear (empty song)
//   i_wr_en/addr/note/dur : synchronous write port
//   i_rd_addr -> o_rd_note/o_rd_dur : combinational read port
module music_seq_table
    import music_seq_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int NOTE_W      = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_wr_en,
    input  logic [$clog2(NUM_ENTRIES)-1:0] i_wr_addr,
    input  logic [NOTE_W-1:0]              i_wr_note,
    input  logic [DUR_W-1:0]               i_wr_dur,
    input  logic [$clog2(NUM_ENTRIES)-1:0] i_rd_addr,
    output logic [NOTE_W-1:0]              o_rd_note,
    output logic [DUR_W-1:0]               o_rd_dur
);
    logic [NOTE_W-1:0] r_note [NUM_ENTRIES];
    logic [DUR_W-1:0]  r_dur  [NUM_ENTRIES];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_note[i] <= '0;
                r_dur[i]  <= '0;
            end
        end else if (i_wr_en) begin
            r_note[i_wr_addr] <= i_wr_note;
            r_dur[i_wr_addr]  <= i_wr_dur;
        end
    end

    assign o_rd_note = r_note[i_rd_addr];
    assign o_rd_dur  = r_dur[i_rd_addr];
endmodule

// File: rtl/music_sequencer.sv
// music_sequencer: plays the stored (note, duration) song by driving an external down-counter
//   i_clk, i_rst                 : clock, asynchronous active-high reset
//   i_wr_en/addr/note/dur        : table write port (accepted only while idle)
//   i_start, i_stop              : begin playback at entry 0 / abort playback
//   i_counter_done               : done flag from the external counter
//   o_counter_load, o_counter_in : counter load strobe and value
//   o_note, o_idx                : sounding note and current entry index
//   o_busy, o_finished           : playback in progress / song-end pulse
// Build option: define MUSIC_SEQ_LOOP_EN to loop the song until stopped.
module music_sequencer
    import music_seq_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int NOTE_W      = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_wr_en,
    input  logic [$clog2(NUM_ENTRIES)-1:0] i_wr_addr,
    input  logic [NOTE_W-1:0]              i_wr_note,
    input  logic [DUR_W-1:0]               i_wr_dur,
    input  logic                           i_start,
    input  logic                           i_stop,
    input  logic                           i_counter_done,
    output logic                           o_counter_load,
    output logic [DUR_W-1:0]               o_counter_in,
    output logic [NOTE_W-1:0]              o_note,
    output logic [$clog2(NUM_ENTRIES)-1:0] o_idx,
    output logic                           o_busy,
    output logic                           o_finished
);
    localparam int AW = $clog2(NUM_ENTRIES);
    localparam logic [AW-1:0] LAST = AW'(NUM_ENTRIES - 1);
`ifdef MUSIC_SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    music_seq_state_t  r_state, w_state_nxt;
    logic [AW-1:0]     r_idx, w_idx_nxt;
    logic              w_fin, w_wr_ok, w_hit;
    logic [NOTE_W-1:0] w_rd_note, w_note, r_note;
    logic [DUR_W-1:0]  w_rd_dur, w_dur, r_counter_in;
    logic              r_counter_load, r_busy, r_finished;

    assign w_wr_ok = i_wr_en && r_state == IDLE;

    // The table is read at the next index so the LOAD outputs can be registered
    music_seq_table #(.NUM_ENTRIES(NUM_ENTRIES), .NOTE_W(NOTE_W)) u_table (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (w_wr_ok),
        .i_wr_addr (i_wr_addr),
        .i_wr_note (i_wr_note),
        .i_wr_dur  (i_wr_dur),
        .i_rd_addr (w_idx_nxt),
        .o_rd_note (w_rd_note),
        .o_rd_dur  (w_rd_dur)
    );

    // Forward a write landing together with start so the first LOAD sees it
    assign w_hit  = w_wr_ok && i_wr_addr == w_idx_nxt;
    assign w_dur  = w_hit ? i_wr_dur  : w_rd_dur;
    assign w_note = w_hit ? i_wr_note : w_rd_note;

    // In LOAD, r_counter_load low means the entry's duration was zero (end marker)
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_fin       = 1'b0;
        case (r_state)
            IDLE: if (i_start) begin
                w_state_nxt = LOAD;
                w_idx_nxt   = '0;
            end
            LOAD: if (i_stop) w_state_nxt = IDLE;
            else if (r_counter_load) w_state_nxt = WAIT;
            else begin
                w_fin = 1'b1;
                if (LOOP && r_idx != '0) begin
                    w_state_nxt = LOAD;
                    w_idx_nxt   = '0;
                end else w_state_nxt = IDLE;
            end
            WAIT: if (i_stop) w_state_nxt = IDLE;
            else if (i_counter_done) w_state_nxt = ADV;
            ADV: if (i_stop) w_state_nxt = IDLE;
            else if (r_idx == LAST) begin
                w_fin = 1'b1;
                w_state_nxt = LOOP ? LOAD : IDLE;
                w_idx_nxt   = '0;
            end else begin
                w_state_nxt = LOAD;
                w_idx_nxt   = r_idx + 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= IDLE;
            r_idx          <= '0;
            r_counter_load <= 1'b0;
            r_counter_in   <= '0;
            r_note         <= '0;
            r_busy         <= 1'b0;
            r_finished     <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_idx          <= w_idx_nxt;
            r_counter_load <= w_state_nxt == LOAD && w_dur != '0;
            r_counter_in   <= w_state_nxt == LOAD ? w_dur : '0;
            r_note         <= w_state_nxt == LOAD ? (w_dur != '0 ? w_note : NOTE_W'(NOTE_REST))
                            : w_state_nxt == IDLE ? NOTE_W'(NOTE_REST) : r_note;
            r_busy         <= w_state_nxt != IDLE;
            r_finished     <= w_fin;
        end
    end

    assign o_counter_load = r_counter_load;
    assign o_counter_in   = r_counter_in;
    assign o_note         = r_note;
    assign o_idx          = r_idx;
    assign o_busy         = r_busy;
    assign o_finished     = r_finished;
endmodule

// File: tb/tb_music_sequencer.sv
// tb_music_sequencer: randomized self-checking bench for music_sequencer against a song-list model
module tb_music_sequencer;
    logic       clk = 1'b0, rst = 1'b1, wr_en = 1'b0, start = 1'b0, stop = 1'b0, force_done = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [3:0] wr_note = '0;
    logic [7:0] wr_dur = '0;
    logic       counter_done, counter_load, busy, finished;
    logic [7:0] counter_in;
    logic [3:0] note;
    logic [2:0] idx;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    music_sequencer #(.NUM_ENTRIES(8), .NOTE_W(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
        .i_wr_note(wr_note), .i_wr_dur(wr_dur), .i_start(start), .i_stop(stop),
        .i_counter_done(counter_done), .o_counter_load(counter_load),
        .o_counter_in(counter_in), .o_note(note), .o_idx(idx),
        .o_busy(busy), .o_finished(finished)
    );

    // down-counter: done is raised N cycles after a load of N
    int cnt;
    always @(posedge clk or posedge rst)
        if (rst) cnt <= 0;
        else if (counter_load) cnt <= int'(counter_in);
        else if (cnt != 0) cnt <= cnt - 1;
    assign counter_done = (cnt == 1) || force_done;

    int m_note[8], m_dur[8];
    int exp_d[$], exp_n[$], obs_d[$], obs_n[$], obs_i[$];
    int exp_cyc, busy_cyc, fin_cnt, cin_bad;
    bit mon_en = 1'b0;

    always @(negedge clk) if (mon_en) begin
        if (busy) busy_cyc++;
        if (finished) fin_cnt++;
        if (counter_load) begin
            obs_d.push_back(int'(counter_in));
            obs_n.push_back(int'(note));
            obs_i.push_back(int'(idx));
        end else if (counter_in != 0) cin_bad++;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tbl_write(input int a, input int n, input int d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'(a); wr_note = 4'(n); wr_dur = 8'(d);
        m_note[a] = n; m_dur[a] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic begin_song(input bit w, input int a, input int n, input int d);
        if (w) begin m_note[a] = n; m_dur[a] = d; end
        exp_d.delete(); exp_n.delete(); exp_cyc = 0;
        for (int i = 0; i < 8 && m_dur[i] != 0; i++) begin
            exp_d.push_back(m_dur[i]);
            exp_n.push_back(m_note[i]);
            exp_cyc += m_dur[i] + 2;
        end
        if (exp_d.size() < 8) exp_cyc++;
        obs_d.delete(); obs_n.delete(); obs_i.delete();
        busy_cyc = 0; fin_cnt = 0; cin_bad = 0; mon_en = 1'b1;
        @(negedge clk);
        start = 1'b1; wr_en = w; wr_addr = 3'(a); wr_note = 4'(n); wr_dur = 8'(d);
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
    endtask

    task automatic end_song(input string tag);
        int c = 0;
        while (fin_cnt == 0 && c < 2000) begin @(negedge clk); c++; end
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        check({tag, "_fin"}, fin_cnt, 1);
        check({tag, "_cycles"}, busy_cyc, exp_cyc);
        check({tag, "_nloads"}, obs_d.size(), exp_d.size());
        for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
            check({tag, "_dur"}, obs_d[i], exp_d[i]);
            check({tag, "_note"}, obs_n[i], exp_n[i]);
            check({tag, "_idx"}, obs_i[i], i);
        end
        check({tag, "_cin_idle"}, cin_bad, 0);
        check({tag, "_busy_end"}, int'(busy), 0);
        check({tag, "_note_end"}, int'(note), 0);
    endtask

    task automatic wait_loads(input string tag, input int n);
        int c = 0;
        while (obs_d.size() < n && c < 500) begin @(negedge clk); c++; end
        check({tag, "_reach"}, int'(obs_d.size() >= n), 1);
        @(negedge clk);
    endtask

    initial begin
        foreach (m_dur[i]) begin m_dur[i] = 0; m_note[i] = 0; end
        #1;
        check("reset_outs", int'({counter_load, counter_in, note, idx, busy, finished}), 0);
        @(negedge clk);
        rst = 1'b0;

        begin_song(1'b0, 0, 0, 0);
        end_song("empty");

        tbl_write(0, 1, 3); tbl_write(1, 2, 5); tbl_write(2, 3, 2); tbl_write(3, 0, 0);
        begin_song(1'b0, 0, 0, 0);
        end_song("three");

        begin_song(1'b1, 0, 7, 2);
        end_song("wr_start");

        for (int r = 0; r < 6; r++) begin
            int len = (r == 0) ? 8 : int'($urandom_range(0, 7));
            for (int i = 0; i < 8; i++)
                tbl_write(i, int'($urandom_range(0, 15)), (i == len) ? 0 : int'($urandom_range(1, 6)));
            begin_song(1'b0, 0, 0, 0);
            end_song(r == 0 ? "full" : "rand");
        end

        for (int i = 0; i < 4; i++) tbl_write(i, i + 1, 6);
        tbl_write(4, 0, 0);
        begin_song(1'b0, 0, 0, 0);
        wait_loads("stop", 2);
        stop = 1'b1; force_done = 1'b1;
        @(negedge clk);
        stop = 1'b0; force_done = 1'b0;
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
        check("stop_busy", int'(busy), 0);
        check("stop_note", int'(note), 0);
        check("stop_idx", int'(idx), 1);
        check("stop_fin", fin_cnt, 0);
        check("stop_nloads", obs_d.size(), 2);

        begin_song(1'b0, 0, 0, 0);
        wait_loads("restart", 2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_idx", int'(idx), 1);
        check("restart_busy", int'(busy), 1);
        end_song("restart");

        begin_song(1'b0, 0, 0, 0);
        wait_loads("wr_busy", 1);
        wr_en = 1'b1; wr_addr = 3'd0; wr_note = 4'd15; wr_dur = 8'd9;
        @(negedge clk);
        wr_addr = 3'd4; wr_dur = 8'd3;
        @(negedge clk);
        wr_en = 1'b0;
        end_song("wr_busy");
        begin_song(1'b0, 0, 0, 0);
        end_song("replay");

        begin_song(1'b0, 0, 0, 0);
        wait_loads("rst_mid", 1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_outs", int'({counter_load, counter_in, note, idx, busy, finished}), 0);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b0;
        foreach (m_dur[i]) begin m_dur[i] = 0; m_note[i] = 0; end
        begin_song(1'b0, 0, 0, 0);
        end_song("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
